sumador_segmentado: RTL and testbench

SUMADOR_SEGMENTADO -- requirements
Module: sumador_segmentado

---
 rtl/sumador_segmentado_if.sv | 28 ++
 rtl/sumador_segmentado.sv | 105 ++++++++++
 tb/tb_sumador_segmentado.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sumador_segmentado_if.sv
// Valid/ready bundle for the pipelined adder/subtractor.
interface sumador_segmentado_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result,
    input  carry, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result,
    output carry, overflow, zero
  );
endinterface

// File: rtl/sumador_segmentado.sv
// Pipelined adder/subtractor, one WIDTH/STAGES slice per stage.
// Define SUMADOR_SAT_EN to saturate the result on signed overflow.
module sumador_segmentado #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  sumador_segmentado_if.slave bus
);
  localparam int SW = WIDTH / STAGES;
  localparam int L  = STAGES - 1;

  typedef logic [WIDTH-1:0] word_t;

  word_t             a_q [STAGES];
  word_t             b_q [STAGES];
  word_t             r_q [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] v_q;
  logic              ovf_q;

  word_t             ac [STAGES];
  word_t             bc [STAGES];
  word_t             rc [STAGES];
  word_t             rn [STAGES];
  logic [STAGES-1:0] ci;
  logic [SW:0]       s [STAGES];

  logic  adv;
  logic  cmsb;
  logic  ovf;
  word_t fin;

  // Whole pipe moves together; it only freezes when the output is blocked.
  assign adv          = !v_q[L] || bus.out_ready;
  assign bus.in_ready = adv;

  // Operands shift right one slice per stage; the result fills from the top.
  always_comb begin
    ac[0] = bus.a;
    bc[0] = bus.sub ? ~bus.b : bus.b;
    ci[0] = bus.sub;
    rc[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      ac[k] = a_q[k-1];
      bc[k] = b_q[k-1];
      ci[k] = c_q[k-1];
      rc[k] = r_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      s[k] = {1'b0, ac[k][SW-1:0]}
           + {1'b0, bc[k][SW-1:0]}
           + (SW+1)'(ci[k]);
      rn[k] = (rc[k] >> SW)
            | (word_t'(s[k][SW-1:0]) << (WIDTH - SW));
    end
  end

  assign cmsb = ac[L][SW-1] ^ bc[L][SW-1] ^ s[L][SW-1];
  assign ovf  = s[L][SW] ^ cmsb;

`ifdef SUMADOR_SAT_EN
  always_comb begin
    fin = rn[L];
    if (ovf) begin
      fin = ac[L][SW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                        : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign fin = rn[L];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
      end
      c_q   <= '0;
      v_q   <= '0;
      ovf_q <= 1'b0;
    end else if (adv) begin
      v_q[0] <= bus.in_valid;
      for (int k = 1; k < STAGES; k++) begin
        v_q[k] <= v_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= ac[k] >> SW;
        b_q[k] <= bc[k] >> SW;
        r_q[k] <= (k == L) ? fin : rn[k];
        c_q[k] <= s[k][SW];
      end
      ovf_q <= ovf;
    end
  end

  assign bus.out_valid = v_q[L];
  assign bus.result    = r_q[L];
  assign bus.carry     = c_q[L];
  assign bus.overflow  = ovf_q;
  assign bus.zero      = (r_q[L] == '0);
endmodule

// File: tb/tb_sumador_segmentado.sv
// Bench for sumador_segmentado: vector table, stall/reset
// sequences and random traffic against an arithmetic model.
module tb_sumador_segmentado;
  localparam int W  = 32;
  localparam int ST = 2;

`ifdef SUMADOR_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [31:0] r;
    logic        c;
    logic        o;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sumador_segmentado_if #(.WIDTH(W)) bus ();

  sumador_segmentado #(
    .WIDTH (W),
    .STAGES(ST)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   got = 0;
  int   sent = 0;
  exp_t q[$];
  exp_t me;
  logic stall_p = 1'b0;
  logic [31:0] h_r;
  logic h_c, h_o, h_z;
  vec_t tab[8];
  bit   done;
  logic [31:0] rx, ry;
  logic rs;
  int   lat, base;

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, req);
    end
  endtask

  function automatic exp_t model(input logic [31:0] x,
                                 input logic [31:0] y,
                                 input logic s);
    exp_t e;
    longint v;
    longint lim;
    logic [63:0] u;
    lim = 64'sd2147483647;
    if (s) v = longint'($signed(x)) - longint'($signed(y));
    else   v = longint'($signed(x)) + longint'($signed(y));
    e.o = (v > lim) || (v < -lim - 1);
    u = {32'd0, x} + {32'd0, y};
    e.c = s ? (x >= y) : u[32];
    e.r = v[31:0];
    if (SAT && e.o) e.r = (v < 0) ? 32'h80000000 : 32'h7fffffff;
    return e;
  endfunction

  function automatic exp_t mk(input logic [31:0] r, input logic c,
                              input logic o);
    exp_t e;
    e.r = r;
    e.c = c;
    e.o = o;
    return e;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y,
                      input logic s, input exp_t e, input bit track);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    bus.in_valid = 1'b1;
    bus.a = x;
    bus.b = y;
    bus.sub = s;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no accept expected accept");
    end else if (track) begin
      q.push_back(e);
      sent++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while (q.size() != 0 && n < 100) begin
      cyc(1);
      n++;
    end
    chk("drain_empty", q.size(), 0);
    cyc(2);
  endtask

  // Output monitor: scoreboard, hold-under-stall and ready rule.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      stall_p = 1'b0;
    end else begin
      chk("in_ready_rule", bus.in_ready,
          !bus.out_valid || bus.out_ready);
      if (stall_p) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_result", bus.result, h_r);
        chk("hold_carry", bus.carry, h_c);
        chk("hold_ovf", bus.overflow, h_o);
        chk("hold_zero", bus.zero, h_z);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %0h expected none",
                   bus.result);
        end else begin
          me = q.pop_front();
          got++;
          chk("result", bus.result, me.r);
          chk("carry", bus.carry, me.c);
          chk("overflow", bus.overflow, me.o);
          chk("zero", bus.zero, me.r == 32'd0);
        end
      end
      stall_p = bus.out_valid && !bus.out_ready;
      h_r = bus.result;
      h_c = bus.carry;
      h_o = bus.overflow;
      h_z = bus.zero;
    end
  end

  initial begin
    tab[0] = '{32'h0000ffff, 32'h00000001, 1'b0,
               mk(32'h00010000, 1'b0, 1'b0)};
    tab[1] = '{32'h7fffffff, 32'h00000001, 1'b0,
               mk(SAT ? 32'h7fffffff : 32'h80000000, 1'b0, 1'b1)};
    tab[2] = '{32'h00000005, 32'h00000005, 1'b1,
               mk(32'h00000000, 1'b1, 1'b0)};
    tab[3] = '{32'h00000000, 32'h00000001, 1'b1,
               mk(32'hffffffff, 1'b0, 1'b0)};
    tab[4] = '{32'hffffffff, 32'h00000001, 1'b0,
               mk(32'h00000000, 1'b1, 1'b0)};
    tab[5] = '{32'h80000000, 32'h00000001, 1'b1,
               mk(SAT ? 32'h80000000 : 32'h7fffffff, 1'b1, 1'b1)};
    tab[6] = '{32'h80000000, 32'h80000000, 1'b0,
               mk(SAT ? 32'h80000000 : 32'h00000000, 1'b1, 1'b1)};
    tab[7] = '{32'h12345678, 32'h11111111, 1'b0,
               mk(32'h23456789, 1'b0, 1'b0)};

    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.sub = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    reset = 1'b1;
    cyc(2);
    @(negedge clk);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_zero", bus.zero, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", bus.out_valid, 0);
    chk("post_rst_result", bus.result, 0);
    chk("post_rst_zero", bus.zero, 1);
    chk("post_rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // Latency of a lone operation, counting the accept edge
    send(32'd10, 32'd20, 1'b0, mk(32'd30, 1'b0, 1'b0), 1'b1);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      cyc(1);
      lat++;
    end
    chk("latency", lat, ST);
    drain();

    // Vector table, back-to-back
    for (int i = 0; i < 8; i++)
      send(tab[i].a, tab[i].b, tab[i].s, tab[i].e, 1'b1);
    drain();

    // Six-deep stream with a 3-cycle output stall
    base = got;
    fork
      for (int i = 0; i < 6; i++)
        send(i, i, 1'b0, mk(2 * i, 1'b0, 1'b0), 1'b1);
      begin
        cyc(3);
        bus.out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          chk("stall_in_ready", bus.in_ready, 0);
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("stream_count", got - base, 6);

    // Reset with two operations in flight
    send(32'd1, 32'd2, 1'b0, mk(32'd3, 1'b0, 1'b0), 1'b0);
    send(32'd3, 32'd4, 1'b0, mk(32'd7, 1'b0, 1'b0), 1'b0);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    @(negedge clk);
    chk("flush_in_ready", bus.in_ready, 1);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("flush_valid", bus.out_valid, 0);
    end
    @(posedge clk);
    #1;
    send(32'd100, 32'd1, 1'b1, mk(32'd99, 1'b1, 1'b0), 1'b1);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      cyc(1);
      lat++;
    end
    chk("latency_after_rst", lat, ST);
    drain();

    // Random traffic with random back-pressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          rx = $urandom;
          ry = $urandom;
          rs = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 4) == 0) rx = 32'h7fffffff;
          if ($urandom_range(0, 4) == 0) ry = 32'h80000000;
          send(rx, ry, rs, model(rx, ry, rs), 1'b1);
          if ($urandom_range(0, 3) == 0) cyc($urandom_range(1, 3));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          bus.out_ready = ($urandom_range(0, 2) != 0);
          cyc(1);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("total_count", got, sent);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
